sprite_blitter: RTL

Raster-scan draw engine that copies one sprite from a sprite RAM onto the VGA frame buffer at a given screen position. It sits between the game-draw scheduler, which issues one blit request per object, and the VGA adapter write port. It drives sprite coordinates into a `sprite_ram_module` instance and absorbs that RAM's 1-cycle read latency. It also drops transparent pixels and clips pixels that fall off-screen.

---
 rtl/sprite_blitter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter
// Copies one sprite from an external sprite RAM onto the VGA frame buffer at a
// given screen position. Transparent pixels are dropped. Pixels that fall
// off-screen are clipped and never wrap back onto the screen.
//
// Ports
//   clk, resetn            : clock (rising edge), asynchronous active-low reset
//   start                  : blit request, sampled only in IDLE
//   pos_x/pos_y            : screen position of the sprite's top-left corner
//   size_x/size_y          : sprite size in pixels
//   spr_x/spr_y            : sprite-RAM read address (registered)
//   spr_color              : sprite-RAM data, one cycle behind spr_x/spr_y
//   vga_x/vga_y/vga_color  : frame-buffer write address/data (registered)
//   vga_plot               : frame-buffer write enable
//   busy                   : high from the cycle after accept through DONE
//   done                   : one-cycle completion pulse
//   dbg_state              : current FSM state (IDLE=0, SCAN=1, FLUSH=2, DONE=3)
//
// Request handshake: a request is taken when start=1 is seen at a rising edge
// while the FSM is in IDLE. The fields pos_*/size_* are captured on that same
// edge. A start seen in any other state is dropped, not queued. busy=0 marks
// the cycles in which a request can be taken.
module sprite_blitter #(
  parameter int             WIDTH_X           = 8,
  parameter int             WIDTH_Y           = 7,
  parameter int             SCREEN_X          = 160,
  parameter int             SCREEN_Y          = 120,
  parameter int             SPRITE_WX         = 4,
  parameter int             SPRITE_WY         = 4,
  parameter logic [2:0]     TRANSPARENT_COLOR = 3'b101
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH_X-1:0]   pos_x,
  input  logic [WIDTH_Y-1:0]   pos_y,
  input  logic [SPRITE_WX-1:0] size_x,
  input  logic [SPRITE_WY-1:0] size_y,
  output logic [SPRITE_WX-1:0] spr_x,
  output logic [SPRITE_WY-1:0] spr_y,
  input  logic [2:0]           spr_color,
  output logic [WIDTH_X-1:0]   vga_x,
  output logic [WIDTH_Y-1:0]   vga_y,
  output logic [2:0]           vga_color,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SPRITE_WX-1:0] ONE_X   = 1;
  localparam logic [SPRITE_WY-1:0] ONE_Y   = 1;
  localparam int                   XPAD    = WIDTH_X + 1 - SPRITE_WX;
  localparam int                   YPAD    = WIDTH_Y + 1 - SPRITE_WY;
  localparam logic [WIDTH_X:0]     X_LIMIT = (WIDTH_X+1)'(SCREEN_X);
  localparam logic [WIDTH_Y:0]     Y_LIMIT = (WIDTH_Y+1)'(SCREEN_Y);

  // Control state and captured request
  state_t                 state_q, state_d;
  logic [WIDTH_X-1:0]     pos_x_q, pos_x_d;
  logic [WIDTH_Y-1:0]     pos_y_q, pos_y_d;
  logic [SPRITE_WX-1:0]   size_x_q, size_x_d;
  logic [SPRITE_WY-1:0]   size_y_q, size_y_d;
  logic [SPRITE_WX-1:0]   spr_x_q, spr_x_d;
  logic [SPRITE_WY-1:0]   spr_y_q, spr_y_d;

  // Stage 1: the address presented last cycle, aligned with spr_color
  logic                   s1_valid_q, s1_valid_d;
  logic [SPRITE_WX-1:0]   s1_sx_q, s1_sx_d;
  logic [SPRITE_WY-1:0]   s1_sy_q, s1_sy_d;

  // Stage 2: frame-buffer write registers
  logic [WIDTH_X-1:0]     vga_x_q, vga_x_d;
  logic [WIDTH_Y-1:0]     vga_y_q, vga_y_d;
  logic [2:0]             vga_color_q, vga_color_d;
  logic                   vga_plot_q, vga_plot_d;

  logic                   x_last, y_last;
  logic [WIDTH_X:0]       sum_x;
  logic [WIDTH_Y:0]       sum_y;

  assign x_last = (spr_x_q == size_x_q - ONE_X);
  assign y_last = (spr_y_q == size_y_q - ONE_Y);

  // One extra bit on the sums means a sprite hanging off the right or bottom
  // edge shows up as out of range rather than wrapping to column/row 0.
  assign sum_x = {1'b0, pos_x_q} + {{XPAD{1'b0}}, s1_sx_q};
  assign sum_y = {1'b0, pos_y_q} + {{YPAD{1'b0}}, s1_sy_q};

  // Next-state logic for the scan FSM and its datapath
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    spr_x_d  = spr_x_q;
    spr_y_d  = spr_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_x_d  = pos_x;
          pos_y_d  = pos_y;
          size_x_d = size_x;
          size_y_d = size_y;
          spr_x_d  = '0;
          spr_y_d  = '0;
          if (size_x == '0 || size_y == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (x_last && y_last) begin
          // Final pixel: the address stays put while the pipeline drains.
          state_d = S_FLUSH;
        end else if (x_last) begin
          spr_x_d = '0;
          spr_y_d = spr_y_q + ONE_Y;
        end else begin
          spr_x_d = spr_x_q + ONE_X;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline next-state logic
  always_comb begin
    s1_valid_d  = (state_q == S_SCAN);
    s1_sx_d     = spr_x_q;
    s1_sy_d     = spr_y_q;
    vga_plot_d  = s1_valid_q && (spr_color != TRANSPARENT_COLOR) &&
                  (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
    // The write registers only move on an actual write, so they hold the
    // last plotted pixel while vga_plot is low.
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    if (vga_plot_d) begin
      vga_x_d     = sum_x[WIDTH_X-1:0];
      vga_y_d     = sum_y[WIDTH_Y-1:0];
      vga_color_d = spr_color;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      size_x_q    <= '0;
      size_y_q    <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_sx_q     <= '0;
      s1_sy_q     <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      size_x_q    <= size_x_d;
      size_y_q    <= size_y_d;
      spr_x_q     <= spr_x_d;
      spr_y_q     <= spr_y_d;
      s1_valid_q  <= s1_valid_d;
      s1_sx_q     <= s1_sx_d;
      s1_sy_q     <= s1_sy_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_plot_q  <= vga_plot_d;
    end
  end

  assign spr_x     = spr_x_q;
  assign spr_y     = spr_y_q;
  assign vga_x     = vga_x_q;
  assign vga_y     = vga_y_q;
  assign vga_color = vga_color_q;
  assign vga_plot  = vga_plot_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
